lock_controller: RTL and testbench
==================================

// Module: lock_controller
// PURPOSE
//  Top-level sequencer for the digital lock. Drives the keypad checkers: length checker and
//  validity checker (readInput, inputWrong, compareType, store), and sequences user-code
//  entry, unlock, failed-attempt lockout, PUK recovery and new-code programming. Uses the
//  blinker through a start/done handshake. Sits in top between enterDigit/checkers and LEDs.
// PARAMETERS
//  MAX_FAILS      3         wrong user codes before lockout (1..7)
//  LOCKOUT_CYC    36000000  hwclk cycles spent in LOCKOUT (3 s @ 12 MHz)
//  UNLOCK_CYC     60000000  hwclk cycles UNLOCKED before auto-relock (5 s)
//  CHANGE_KEY     4'd9      key that, pressed while UNLOCKED, starts new-code entry
//  CW             26        width of the shared cycle timer (must hold max(LOCKOUT_CYC,UNLOCK_CYC))
// PORTS
//  hwclk        in   1   system clock, 12 MHz
//  rst_n        in   1   asynchronous active-low reset
//  bstate       in   1   keypad pressed level from enterDigit, hwclk-synchronous
//  button       in   4   key code, valid while bstate=1
//  validUC      in   1   length checker: 6 digits entered for user code
//  validPC      in   1   length checker: 6 digits entered for PUK
//  correct      in   1   validity checker: current entry matches compareType target
//  newUC        in   1   validity checker: 1-cycle pulse, new user code stored
//  blink_done   in   1   blinker: 1-cycle pulse, blink sequence finished
//  readInput    out  1   checkers accept digits
//  inputWrong   out  1   1-cycle pulse clearing checker digit buffers
//  compareType  out  2   00 none, 01 user code, 10 PUK
//  store        out  1   checker stores entered digits as new user code
//  blink_start  out  1   1-cycle pulse starting blinker
//  blink_type   out  1   0 = success pattern, 1 = error pattern
//  unlocked     out  1   lock open
//  locked_out   out  1   lockout/PUK-required indicator
//  fail_count   out  3   consecutive wrong user codes, saturating at MAX_FAILS
// BEHAVIOUR
//  Reset (async, rst_n=0): state=LOCKED, timer=0, fail_count=0, all outputs 0 except
//   readInput=1, compareType=01. Release is taken at the next hwclk edge.
//  Key event = falling edge of bstate, detected with one registered copy of bstate. Latch
//   button when bstate=1 and use the latched value on release.
//  All outputs are registered. validUC/validPC are edge-detected (rising). Only the one
//   matching the current state is acted on; the other is ignored.
//  LOCKED: readInput=1, cmp=01. validUC rise -> CHECK_UC.
//  CHECK_UC (1 cycle; correct sampled here): on a match go to OPEN, fail_count:=0,
//   blink_start with type 0. On a mismatch, inputWrong pulse, fail_count+1 (saturating) and
//   blink_start with type 1. Go to LOCKOUT if the new count equals MAX_FAILS, else WAIT_BLINK.
//  WAIT_BLINK: readInput=0. Stay until blink_done, then go to LOCKED.
//  OPEN: unlocked=1, readInput=0, timer counts up. Timer reaching UNLOCK_CYC-1 -> LOCKED
//   with inputWrong pulse. A key event with key == CHANGE_KEY -> NEW_UC and timer:=0.
//   Other keys are ignored.
//  NEW_UC: readInput=1, store=1, cmp=01, unlocked=1. On a newUC pulse, go to LOCKED with
//   unlocked:=0. An entry that completes without newUC is not special; stay in state.
//  LOCKOUT: locked_out=1, readInput=0, cmp=00. Key events are ignored. The timer counts;
//   at LOCKOUT_CYC-1 go to PUK with timer:=0 and an inputWrong pulse.
//  PUK: locked_out=1, readInput=1, cmp=10. validPC rise -> CHECK_PC.
//  CHECK_PC (1 cycle): on a match, fail_count:=0 and locked_out:=0, then go to NEW_UC. On a
//   mismatch, inputWrong pulse and go back to LOCKOUT with timer:=0.
//  Timer is cleared on every state change. It never wraps; the terminal compare ends the state.
//  blink_done is ignored outside WAIT_BLINK. blink_start and inputWrong never last >1 cycle.
//  Latency: validUC rise -> unlocked=1 is 2 hwclk cycles (edge register + CHECK_UC).
// TESTING
//  Reset, then 6-digit entry with correct=1 at validUC -> unlocked=1 after 2 cycles,
//   blink_start type 0, fail_count=0.
//  3 wrong entries (MAX_FAILS=3) with blink_done each -> fail_count 1,2,3 and locked_out=1
//   after the 3rd. Keys during lockout are ignored.
//  LOCKOUT_CYC=20 -> PUK at cycle 20 (cmp=10). Wrong PUK -> LOCKOUT again. Correct PUK ->
//   NEW_UC with store=1, then newUC -> LOCKED.
//  OPEN with UNLOCK_CYC=16, no keys -> relock at cycle 16 with inputWrong pulse. A key
//   CHANGE_KEY at cycle 5 -> NEW_UC instead.
//  validUC and validPC asserted together in LOCKED -> CHECK_UC only. In PUK -> CHECK_PC only.
//  rst_n low mid-LOCKOUT and mid-NEW_UC -> immediate LOCKED state, outputs at reset values,
//   fail_count=0.

Source files
------------

// File: rtl/lock_controller.sv
// Top-level sequencer for the digital lock: user-code entry, unlock, lockout,
// PUK recovery and new-code programming, all with registered outputs.
module lock_controller #(
   parameter int unsigned MAX_FAILS   = 3,
   parameter int unsigned LOCKOUT_CYC = 36000000,
   parameter int unsigned UNLOCK_CYC  = 60000000,
   parameter logic [3:0]  CHANGE_KEY  = 4'd9,
   parameter int unsigned CW          = 26
) (
   input  logic       hwclk,
   input  logic       rst_n,
   input  logic       bstate,
   input  logic [3:0] button,
   input  logic       validUC,
   input  logic       validPC,
   input  logic       correct,
   input  logic       newUC,
   input  logic       blink_done,
   output logic       readInput,
   output logic       inputWrong,
   output logic [1:0] compareType,
   output logic       store,
   output logic       blink_start,
   output logic       blink_type,
   output logic       unlocked,
   output logic       locked_out,
   output logic [2:0] fail_count
);

   localparam logic [2:0] S_LOCKED     = 3'd0;
   localparam logic [2:0] S_CHECK_UC   = 3'd1;
   localparam logic [2:0] S_WAIT_BLINK = 3'd2;
   localparam logic [2:0] S_OPEN       = 3'd3;
   localparam logic [2:0] S_NEW_UC     = 3'd4;
   localparam logic [2:0] S_LOCKOUT    = 3'd5;
   localparam logic [2:0] S_PUK        = 3'd6;
   localparam logic [2:0] S_CHECK_PC   = 3'd7;

   localparam logic [2:0]    MAX_F        = 3'(MAX_FAILS);
   localparam logic [CW-1:0] UNLOCK_TERM  = CW'(UNLOCK_CYC - 1);
   localparam logic [CW-1:0] LOCKOUT_TERM = CW'(LOCKOUT_CYC - 1);

   logic [2:0]    r_state;
   logic [CW-1:0] r_timer;
   logic [2:0]    r_fail;
   logic          r_bstate_d;
   logic          r_uc_d;
   logic          r_pc_d;
   logic [3:0]    r_key;

   logic          r_readInput;
   logic          r_inputWrong;
   logic [1:0]    r_cmp;
   logic          r_store;
   logic          r_blink_start;
   logic          r_blink_type;
   logic          r_unlocked;
   logic          r_locked_out;

   logic          w_key_ev;
   logic          w_uc_rise;
   logic          w_pc_rise;
   logic [2:0]    w_fail_inc;

   logic [2:0]    w_state_nx;
   logic [CW-1:0] w_timer_nx;
   logic [2:0]    w_fail_nx;
   logic          w_iw_nx;
   logic          w_bs_nx;
   logic          w_bt_nx;

   logic          w_ri_nx;
   logic [1:0]    w_cmp_nx;
   logic          w_store_nx;
   logic          w_unl_nx;
   logic          w_lo_nx;

   assign w_key_ev   = r_bstate_d & ~bstate;
   assign w_uc_rise  = validUC & ~r_uc_d;
   assign w_pc_rise  = validPC & ~r_pc_d;
   assign w_fail_inc = (r_fail == MAX_F) ? r_fail : r_fail + 3'd1;

   // The key code is only meaningful while pressed, so it is held for use on release.
   always_ff @(posedge hwclk) begin
      if (bstate) begin
         r_key <= button;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_fail_nx  = r_fail;
      w_iw_nx    = 1'b0;
      w_bs_nx    = 1'b0;
      w_bt_nx    = r_blink_type;
      case (r_state)
         S_LOCKED: begin
            if (w_uc_rise) begin
               w_state_nx = S_CHECK_UC;
            end
         end
         S_CHECK_UC: begin
            w_bs_nx = 1'b1;
            if (correct) begin
               w_state_nx = S_OPEN;
               w_fail_nx  = 3'd0;
               w_bt_nx    = 1'b0;
            end else begin
               w_iw_nx    = 1'b1;
               w_fail_nx  = w_fail_inc;
               w_bt_nx    = 1'b1;
               w_state_nx = (w_fail_inc == MAX_F) ? S_LOCKOUT : S_WAIT_BLINK;
            end
         end
         S_WAIT_BLINK: begin
            if (blink_done) begin
               w_state_nx = S_LOCKED;
            end
         end
         S_OPEN: begin
            if (r_timer == UNLOCK_TERM) begin
               w_state_nx = S_LOCKED;
               w_iw_nx    = 1'b1;
            end else if (w_key_ev && (r_key == CHANGE_KEY)) begin
               w_state_nx = S_NEW_UC;
            end
         end
         S_NEW_UC: begin
            if (newUC) begin
               w_state_nx = S_LOCKED;
            end
         end
         S_LOCKOUT: begin
            if (r_timer == LOCKOUT_TERM) begin
               w_state_nx = S_PUK;
               w_iw_nx    = 1'b1;
            end
         end
         S_PUK: begin
            if (w_pc_rise) begin
               w_state_nx = S_CHECK_PC;
            end
         end
         S_CHECK_PC: begin
            if (correct) begin
               w_fail_nx  = 3'd0;
               w_state_nx = S_NEW_UC;
            end else begin
               w_iw_nx    = 1'b1;
               w_state_nx = S_LOCKOUT;
            end
         end
         default: begin
            w_state_nx = S_LOCKED;
         end
      endcase
   end

   // Timer only advances in the two timed states; the terminal compare leaves them.
   always_comb begin
      w_timer_nx = r_timer;
      if (w_state_nx != r_state) begin
         w_timer_nx = '0;
      end else if ((r_state == S_OPEN) || (r_state == S_LOCKOUT)) begin
         w_timer_nx = r_timer + CW'(1);
      end
   end

   // Level outputs are decoded from the next state so they register in step with it.
   always_comb begin
      w_ri_nx    = 1'b1;
      w_cmp_nx   = 2'b01;
      w_store_nx = 1'b0;
      w_unl_nx   = 1'b0;
      w_lo_nx    = 1'b0;
      case (w_state_nx)
         S_WAIT_BLINK: begin
            w_ri_nx = 1'b0;
         end
         S_OPEN: begin
            w_ri_nx  = 1'b0;
            w_unl_nx = 1'b1;
         end
         S_NEW_UC: begin
            w_store_nx = 1'b1;
            w_unl_nx   = 1'b1;
         end
         S_LOCKOUT: begin
            w_ri_nx  = 1'b0;
            w_cmp_nx = 2'b00;
            w_lo_nx  = 1'b1;
         end
         S_PUK, S_CHECK_PC: begin
            w_cmp_nx = 2'b10;
            w_lo_nx  = 1'b1;
         end
         default: begin
            w_ri_nx = 1'b1;
         end
      endcase
   end

   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_LOCKED;
         r_timer       <= '0;
         r_fail        <= 3'd0;
         r_bstate_d    <= 1'b0;
         r_uc_d        <= 1'b0;
         r_pc_d        <= 1'b0;
         r_readInput   <= 1'b1;
         r_inputWrong  <= 1'b0;
         r_cmp         <= 2'b01;
         r_store       <= 1'b0;
         r_blink_start <= 1'b0;
         r_blink_type  <= 1'b0;
         r_unlocked    <= 1'b0;
         r_locked_out  <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_timer       <= w_timer_nx;
         r_fail        <= w_fail_nx;
         r_bstate_d    <= bstate;
         r_uc_d        <= validUC;
         r_pc_d        <= validPC;
         r_readInput   <= w_ri_nx;
         r_inputWrong  <= w_iw_nx;
         r_cmp         <= w_cmp_nx;
         r_store       <= w_store_nx;
         r_blink_start <= w_bs_nx;
         r_blink_type  <= w_bt_nx;
         r_unlocked    <= w_unl_nx;
         r_locked_out  <= w_lo_nx;
      end
   end

   assign readInput   = r_readInput;
   assign inputWrong  = r_inputWrong;
   assign compareType = r_cmp;
   assign store       = r_store;
   assign blink_start = r_blink_start;
   assign blink_type  = r_blink_type;
   assign unlocked    = r_unlocked;
   assign locked_out  = r_locked_out;
   assign fail_count  = r_fail;

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller with short timer parameters.
module tb_lock_controller;

   logic       hwclk;
   logic       rst_n;
   logic       bstate;
   logic [3:0] button;
   logic       validUC;
   logic       validPC;
   logic       correct;
   logic       newUC;
   logic       blink_done;
   logic       readInput;
   logic       inputWrong;
   logic [1:0] compareType;
   logic       store;
   logic       blink_start;
   logic       blink_type;
   logic       unlocked;
   logic       locked_out;
   logic [2:0] fail_count;

   int n_cmp = 0;
   int n_err = 0;

   lock_controller #(
      .MAX_FAILS  (3),
      .LOCKOUT_CYC(20),
      .UNLOCK_CYC (16),
      .CHANGE_KEY (4'd9),
      .CW         (8)
   ) dut (
      .hwclk      (hwclk),
      .rst_n      (rst_n),
      .bstate     (bstate),
      .button     (button),
      .validUC    (validUC),
      .validPC    (validPC),
      .correct    (correct),
      .newUC      (newUC),
      .blink_done (blink_done),
      .readInput  (readInput),
      .inputWrong (inputWrong),
      .compareType(compareType),
      .store      (store),
      .blink_start(blink_start),
      .blink_type (blink_type),
      .unlocked   (unlocked),
      .locked_out (locked_out),
      .fail_count (fail_count)
   );

   initial begin
      hwclk = 1'b0;
      forever #5 hwclk = ~hwclk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge hwclk);
         #1;
      end
   endtask

   task automatic enter_uc(input logic c);
      correct = c;
      validUC = 1'b1;
      tick();
      validUC = 1'b0;
      tick();
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_ri"},    32'(readInput),   1);
      check_eq({tag, "_cmp"},   32'(compareType), 1);
      check_eq({tag, "_unl"},   32'(unlocked),    0);
      check_eq({tag, "_lo"},    32'(locked_out),  0);
      check_eq({tag, "_fail"},  32'(fail_count),  0);
      check_eq({tag, "_store"}, 32'(store),       0);
      check_eq({tag, "_iw"},    32'(inputWrong),  0);
      check_eq({tag, "_bs"},    32'(blink_start), 0);
   endtask

   initial begin
      rst_n      = 1'b0;
      bstate     = 1'b0;
      button     = 4'd0;
      validUC    = 1'b0;
      validPC    = 1'b0;
      correct    = 1'b0;
      newUC      = 1'b0;
      blink_done = 1'b0;
      tick(2);
      check_reset_vals("rst");
      rst_n = 1'b1;
      tick();

      // correct user code: unlocked two edges after validUC rises
      correct = 1'b1;
      validUC = 1'b1;
      tick();
      check_eq("uc_lat1_unl", 32'(unlocked), 0);
      tick();
      validUC = 1'b0;
      check_eq("open_unl",  32'(unlocked),    1);
      check_eq("open_bs",   32'(blink_start), 1);
      check_eq("open_bt",   32'(blink_type),  0);
      check_eq("open_fail", 32'(fail_count),  0);
      check_eq("open_ri",   32'(readInput),   0);
      tick();
      check_eq("open_bs_pulse", 32'(blink_start), 0);
      tick(14);
      check_eq("open15_unl", 32'(unlocked),   1);
      check_eq("open15_iw",  32'(inputWrong), 0);
      tick();
      check_eq("relock_unl", 32'(unlocked),   0);
      check_eq("relock_iw",  32'(inputWrong), 1);
      check_eq("relock_ri",  32'(readInput),  1);
      tick();
      check_eq("relock_iw_pulse", 32'(inputWrong), 0);

      // three wrong codes lead into lockout
      for (int i = 1; i <= 3; i++) begin
         enter_uc(1'b0);
         check_eq("wrong_fail", 32'(fail_count),  i);
         check_eq("wrong_bs",   32'(blink_start), 1);
         check_eq("wrong_bt",   32'(blink_type),  1);
         check_eq("wrong_iw",   32'(inputWrong),  1);
         if (i < 3) begin
            check_eq("wait_ri", 32'(readInput),  0);
            check_eq("wait_lo", 32'(locked_out), 0);
            blink_done = 1'b1;
            tick();
            blink_done = 1'b0;
            check_eq("back_locked_ri", 32'(readInput), 1);
         end
      end
      check_eq("lockout_lo",  32'(locked_out),  1);
      check_eq("lockout_cmp", 32'(compareType), 0);
      check_eq("lockout_ri",  32'(readInput),   0);
      bstate = 1'b1;
      button = 4'd9;
      tick();
      bstate = 1'b0;
      tick();
      validUC = 1'b1;
      tick();
      validUC = 1'b0;
      check_eq("lockout_keys_lo",  32'(locked_out),  1);
      check_eq("lockout_keys_unl", 32'(unlocked),    0);
      check_eq("lockout_keys_cmp", 32'(compareType), 0);
      tick(16);
      check_eq("lockout19_cmp", 32'(compareType), 0);
      check_eq("lockout19_iw",  32'(inputWrong),  0);
      tick();
      check_eq("puk_cmp", 32'(compareType), 2);
      check_eq("puk_ri",  32'(readInput),   1);
      check_eq("puk_iw",  32'(inputWrong),  1);
      check_eq("puk_lo",  32'(locked_out),  1);

      // wrong PUK returns to a fresh lockout
      correct = 1'b0;
      validPC = 1'b1;
      tick();
      validPC = 1'b0;
      tick();
      check_eq("badpuk_cmp",  32'(compareType), 0);
      check_eq("badpuk_iw",   32'(inputWrong),  1);
      check_eq("badpuk_lo",   32'(locked_out),  1);
      check_eq("badpuk_fail", 32'(fail_count),  3);
      tick(19);
      check_eq("relockout19_cmp", 32'(compareType), 0);
      tick();
      check_eq("repuk_cmp", 32'(compareType), 2);

      // validUC and validPC together in PUK: only the PUK check runs
      correct = 1'b1;
      validUC = 1'b1;
      validPC = 1'b1;
      tick();
      validUC = 1'b0;
      validPC = 1'b0;
      tick();
      check_eq("newuc_store", 32'(store),       1);
      check_eq("newuc_unl",   32'(unlocked),    1);
      check_eq("newuc_lo",    32'(locked_out),  0);
      check_eq("newuc_fail",  32'(fail_count),  0);
      check_eq("newuc_bs",    32'(blink_start), 0);
      check_eq("newuc_cmp",   32'(compareType), 1);
      enter_uc(1'b1);
      check_eq("newuc_stay_store", 32'(store), 1);
      newUC = 1'b1;
      tick();
      newUC = 1'b0;
      check_eq("stored_store", 32'(store),       0);
      check_eq("stored_unl",   32'(unlocked),    0);
      check_eq("stored_ri",    32'(readInput),   1);
      check_eq("stored_cmp",   32'(compareType), 1);

      // validUC and validPC together in LOCKED: only the user-code check runs
      correct = 1'b1;
      validUC = 1'b1;
      validPC = 1'b1;
      tick();
      validUC = 1'b0;
      validPC = 1'b0;
      tick();
      check_eq("both_unl",   32'(unlocked),    1);
      check_eq("both_store", 32'(store),       0);
      check_eq("both_bs",    32'(blink_start), 1);
      check_eq("both_lo",    32'(locked_out),  0);
      bstate = 1'b1;
      button = 4'd3;
      tick();
      bstate = 1'b0;
      tick();
      check_eq("otherkey_unl",   32'(unlocked), 1);
      check_eq("otherkey_store", 32'(store),    0);
      bstate = 1'b1;
      button = 4'd9;
      tick(2);
      bstate = 1'b0;
      button = 4'd0;
      tick();
      check_eq("chgkey_store", 32'(store),     1);
      check_eq("chgkey_unl",   32'(unlocked),  1);
      check_eq("chgkey_ri",    32'(readInput), 1);

      // asynchronous reset while in NEW_UC
      rst_n = 1'b0;
      #2;
      check_reset_vals("rst_newuc");
      tick();
      rst_n = 1'b1;
      tick();

      // asynchronous reset while in LOCKOUT
      for (int i = 1; i <= 3; i++) begin
         enter_uc(1'b0);
         if (i < 3) begin
            blink_done = 1'b1;
            tick();
            blink_done = 1'b0;
         end
      end
      check_eq("lockout2_lo",   32'(locked_out), 1);
      check_eq("lockout2_fail", 32'(fail_count), 3);
      tick(3);
      rst_n = 1'b0;
      #2;
      check_reset_vals("rst_lockout");
      tick();
      rst_n = 1'b1;
      tick();

      enter_uc(1'b1);
      check_eq("post_rst_unl", 32'(unlocked), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
